// File: rtl/nbj_next_pc_unit.sv
// Next-PC / cut stage: picks the first taken lane of a fetch packet and emits the next fetch PC
// plus a keep-mask on a registered valid/ready port; back-end redirects preempt it. Option: NBJ_PERF_CNT_EN.
module nbj_next_pc_unit #(
    parameter int LANES = 10,
    parameter int ADDR_W = 32,
    parameter int TYPE_W = 3,
    parameter int INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int CNT_W = $clog2(LANES + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_frontValid,
    output logic                             o_frontReady,
    input  logic [LANES-1:0]                 i_jumpMask,
    input  logic [CNT_W-1:0]                 i_alignedInstructionNumber,
    input  logic [ADDR_W-1:0]                i_currentPc,
    input  logic [LANES*(TYPE_W+ADDR_W)-1:0] i_typeAndAddressTableBus,
    input  logic                             i_correctValid,
    input  logic [ADDR_W-1:0]                i_correctPc,
    input  logic [$clog2(LANES)-1:0]         i_correctPcIndex,
    input  logic                             i_correctType,
    output logic                             o_outValid,
    input  logic                             i_outReady,
    output logic [ADDR_W-1:0]                o_nextPc,
    output logic [LANES-1:0]                 o_cutPosition,
    output logic                             o_clear,
`ifdef NBJ_PERF_CNT_EN
    output logic [31:0]                      o_takenCount,
    output logic [31:0]                      o_redirectCount,
`endif
    output logic [1:0]                       o_debugState
);

    localparam int LANE_W = TYPE_W + ADDR_W;

    typedef enum logic [1:0] {IDLE, HOLD, REDIR} state_t;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] nextPcReg, nextPcNext;
    logic [LANES-1:0]  cutReg, cutNext;
    logic              takenReg, takenNext;

    logic [CNT_W-1:0]  laneCount;
    logic [TYPE_W-1:0] laneType;
    logic              foundTaken;
    logic [ADDR_W-1:0] normalPc;
    logic [LANES-1:0]  normalCut;
    logic [ADDR_W-1:0] redirPc;
    logic [LANES-1:0]  redirCut;
    logic              newBeat;

    // Handshake: the front packet transfers on a cycle where i_frontValid && o_frontReady at the
    // rising edge; the output beat transfers where o_outValid && i_outReady, and holds until then.
    assign o_frontReady = !i_correctValid && ((state == IDLE) || ((state == HOLD) && i_outReady));
    assign newBeat = i_frontValid && o_frontReady && (i_alignedInstructionNumber != '0);

    // Scan from the top lane downwards so the lowest qualifying lane is the one left standing.
    always_comb begin
        laneCount  = (i_alignedInstructionNumber > CNT_W'(LANES)) ? CNT_W'(LANES)
                                                                  : i_alignedInstructionNumber;
        laneType   = '0;
        foundTaken = 1'b0;
        normalPc   = i_currentPc + ADDR_W'(INST_BYTES) * ADDR_W'(laneCount);
        normalCut  = '0;
        for (int k = 0; k < LANES; k++) normalCut[k] = (k < int'(laneCount));
        for (int k = LANES - 1; k >= 0; k--) begin
            laneType = i_typeAndAddressTableBus[k*LANE_W+ADDR_W +: TYPE_W];
            if (i_jumpMask[k] && (k < int'(laneCount)) &&
                ((laneType == TYPE_W'(1)) || (laneType == TYPE_W'(2)) || (laneType == TYPE_W'(4)))) begin
                foundTaken = 1'b1;
                normalPc   = i_typeAndAddressTableBus[k*LANE_W +: ADDR_W];
                for (int j = 0; j < LANES; j++) normalCut[j] = (j <= k);
            end
        end
    end

    always_comb begin
        redirPc  = i_correctType ? i_correctPc : i_correctPc + ADDR_W'(INST_BYTES);
        redirCut = '0;
        for (int k = 0; k < LANES; k++) redirCut[k] = (k <= int'(i_correctPcIndex));
    end

    always_comb begin
        stateNext  = state;
        nextPcNext = nextPcReg;
        cutNext    = cutReg;
        takenNext  = takenReg;
        if (i_correctValid) begin
            stateNext  = REDIR;
            nextPcNext = redirPc;
            cutNext    = redirCut;
            takenNext  = 1'b0;
        end else if (newBeat) begin
            stateNext  = HOLD;
            nextPcNext = normalPc;
            cutNext    = normalCut;
            takenNext  = foundTaken;
        end else if ((state != IDLE) && i_outReady) begin
            stateNext = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            nextPcReg <= RESET_PC;
            cutReg    <= '0;
            takenReg  <= 1'b0;
        end else begin
            state     <= stateNext;
            nextPcReg <= nextPcNext;
            cutReg    <= cutNext;
            takenReg  <= takenNext;
        end
    end

    assign o_outValid    = (state != IDLE);
    assign o_clear       = (state == REDIR);
    assign o_nextPc      = nextPcReg;
    assign o_cutPosition = cutReg;
    assign o_debugState  = state;

`ifdef NBJ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_takenCount    <= '0;
            o_redirectCount <= '0;
        end else if (o_outValid && i_outReady) begin
            if ((state == HOLD) && takenReg && (o_takenCount != '1))
                o_takenCount <= o_takenCount + 32'd1;
            if ((state == REDIR) && (o_redirectCount != '1))
                o_redirectCount <= o_redirectCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nbj_next_pc_unit.sv
// Self-checking bench for nbj_next_pc_unit: directed scenarios followed by random traffic,
// checked against a one-deep expected-beat queue built from packet arithmetic.
module tb_nbj_next_pc_unit;

    localparam int LANES = 10;
    localparam int ADDR_W = 32;
    localparam int TYPE_W = 3;
    localparam int CNT_W = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [9:0]  cut;
        logic        clear;
        logic        taken;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic frontValid, frontReady;
    logic [LANES-1:0] jumpMask;
    logic [CNT_W-1:0] count;
    logic [31:0] currentPc;
    logic [LANES*(TYPE_W+ADDR_W)-1:0] tableBus;
    logic correctValid;
    logic [31:0] correctPc;
    logic [3:0] correctIdx;
    logic correctType;
    logic outValid, outReady;
    logic [31:0] nextPc;
    logic [9:0] cutPos;
    logic clear;
    logic [1:0] dbgState;
`ifdef NBJ_PERF_CNT_EN
    logic [31:0] takenCount, redirectCount;
`endif

    logic [2:0]  types[LANES];
    logic [31:0] targets[LANES];

    beat_t exp_q[$];
    int tests = 0;
    int fails = 0;
    longint expTaken = 0;
    longint expRedir = 0;

    nbj_next_pc_unit #(.LANES(LANES), .ADDR_W(ADDR_W), .TYPE_W(TYPE_W), .INST_BYTES(4),
                       .RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_frontValid(frontValid), .o_frontReady(frontReady),
        .i_jumpMask(jumpMask), .i_alignedInstructionNumber(count),
        .i_currentPc(currentPc), .i_typeAndAddressTableBus(tableBus),
        .i_correctValid(correctValid), .i_correctPc(correctPc),
        .i_correctPcIndex(correctIdx), .i_correctType(correctType),
        .o_outValid(outValid), .i_outReady(outReady),
        .o_nextPc(nextPc), .o_cutPosition(cutPos), .o_clear(clear),
`ifdef NBJ_PERF_CNT_EN
        .o_takenCount(takenCount), .o_redirectCount(redirectCount),
`endif
        .o_debugState(dbgState)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_table();
        for (int k = 0; k < LANES; k++)
            tableBus[k*(TYPE_W+ADDR_W) +: TYPE_W+ADDR_W] = {types[k], targets[k]};
    endtask

    function automatic logic [9:0] low_ones(input int n);
        longint v;
        v = (64'd1 << n) - 1;
        return v[9:0];
    endfunction

    function automatic beat_t normal_beat();
        beat_t b;
        int n;
        n = (int'(count) > LANES) ? LANES : int'(count);
        b.clear = 1'b0;
        b.taken = 1'b0;
        b.pc    = currentPc + 32'(4 * n);
        b.cut   = low_ones(n);
        for (int k = 0; k < n; k++) begin
            if (!b.taken && jumpMask[k] && (types[k] == 3'd1 || types[k] == 3'd2 || types[k] == 3'd4)) begin
                b.taken = 1'b1;
                b.pc    = targets[k];
                b.cut   = low_ones(k + 1);
            end
        end
        return b;
    endfunction

    function automatic beat_t redirect_beat();
        beat_t b;
        b.clear = 1'b1;
        b.taken = 1'b0;
        b.pc    = correctType ? correctPc : correctPc + 32'd4;
        b.cut   = low_ones(int'(correctIdx) + 1);
        return b;
    endfunction

    // One clock: check readiness, advance the reference across the edge, then check the beat.
    task automatic step();
        logic expReady, accept, justReset;
        @(negedge clk);
        expReady = !correctValid && (exp_q.size() == 0 || (!exp_q[0].clear && outReady));
        if (rst) check("frontReady", {63'd0, frontReady}, {63'd0, expReady});
        accept = rst && frontValid && expReady;
        @(posedge clk);
        #1;
        justReset = !rst;
        if (!rst) begin
            exp_q.delete();
            expTaken = 0;
            expRedir = 0;
        end else begin
            if (exp_q.size() != 0 && outReady) begin
                if (exp_q[0].clear) expRedir++;
                else if (exp_q[0].taken) expTaken++;
                void'(exp_q.pop_front());
            end
            if (correctValid) begin
                exp_q.delete();
                exp_q.push_back(redirect_beat());
            end else if (accept && count != 0) begin
                exp_q.push_back(normal_beat());
            end
        end
        check("outValid", {63'd0, outValid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("nextPc", {32'd0, nextPc}, {32'd0, exp_q[0].pc});
            check("cut", {54'd0, cutPos}, {54'd0, exp_q[0].cut});
            check("clear", {63'd0, clear}, {63'd0, exp_q[0].clear});
        end else begin
            check("clearIdle", {63'd0, clear}, 64'd0);
        end
        if (justReset) begin
            check("resetPc", {32'd0, nextPc}, {32'd0, RST_PC});
            check("resetCut", {54'd0, cutPos}, 64'd0);
        end
`ifdef NBJ_PERF_CNT_EN
        check("takenCount", {32'd0, takenCount}, 64'(expTaken));
        check("redirectCount", {32'd0, redirectCount}, 64'(expRedir));
`endif
    endtask

    task automatic set_packet(input int cnt, input logic [9:0] mask, input logic [31:0] pc);
        frontValid = 1'b1;
        count      = CNT_W'(cnt);
        jumpMask   = mask;
        currentPc  = pc;
        pack_table();
    endtask

    initial begin
        rst = 1'b0; frontValid = 1'b0; jumpMask = '0; count = '0; currentPc = '0;
        correctValid = 1'b0; correctPc = '0; correctIdx = '0; correctType = 1'b0; outReady = 1'b1;
        for (int k = 0; k < LANES; k++) begin types[k] = 3'd0; targets[k] = 32'(k * 32'h111); end
        pack_table();

        // Reset
        step(); step();
        rst = 1'b1;

        // Fall-through packet of four
        set_packet(4, 10'h000, 32'h1000);
        step();
        check("tp_fall_pc", {32'd0, nextPc}, 64'h1010);
        check("tp_fall_cut", {54'd0, cutPos}, 64'h00F);

        // Lane 2 is type 3 (falls through); lane 5 direct jump wins
        types[2] = 3'd3; targets[2] = 32'h4000;
        types[5] = 3'd1; targets[5] = 32'h8000;
        set_packet(8, 10'h024, 32'h1010);
        step();
        check("tp_jump_pc", {32'd0, nextPc}, 64'h8000);
        check("tp_jump_cut", {54'd0, cutPos}, 64'h03F);

        // Drain, then stall a held beat for three cycles
        frontValid = 1'b0;
        step();
        set_packet(3, 10'h000, 32'h2000);
        outReady = 1'b0;
        step();
        set_packet(10, 10'h000, 32'h3000);
        repeat (3) begin
            step();
            check("stall_pc", {32'd0, nextPc}, 64'h200C);
        end
        outReady = 1'b1;
        step();
        check("b2b_pc", {32'd0, nextPc}, 64'h3028);
        check("b2b_cut", {54'd0, cutPos}, 64'h3FF);

        // Redirect beats the concurrent packet
        set_packet(2, 10'h000, 32'h5000);
        correctValid = 1'b1; correctPc = 32'h2000; correctType = 1'b0; correctIdx = 4'd3;
        step();
        check("redir_pc", {32'd0, nextPc}, 64'h2004);
        check("redir_cut", {54'd0, cutPos}, 64'h00F);
        check("redir_clear", {63'd0, clear}, 64'd1);
        correctValid = 1'b0; frontValid = 1'b0;
        step();

        // Redirect drops a held normal beat; second redirect replaces the first
        set_packet(15, 10'h000, 32'hFFFF_FFF0);
        outReady = 1'b0;
        step();
        frontValid = 1'b0;
        correctValid = 1'b1; correctPc = 32'h3000; correctType = 1'b1; correctIdx = 4'd9;
        step();
        correctPc = 32'h6000; correctType = 1'b0; correctIdx = 4'd0;
        step();
        correctValid = 1'b0; outReady = 1'b1;
        step();

        // Zero-count packet yields no beat
        set_packet(0, 10'h3FF, 32'h7000);
        step();
        frontValid = 1'b0;

        // Reset while holding a beat
        set_packet(5, 10'h000, 32'h9000);
        outReady = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        outReady = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < LANES; k++) begin
                types[k]   = 3'($urandom_range(0, 7));
                targets[k] = $urandom();
            end
            set_packet($urandom_range(0, 15), 10'($urandom()), $urandom());
            frontValid   = ($urandom_range(0, 3) != 0);
            outReady     = ($urandom_range(0, 3) != 0);
            correctValid = ($urandom_range(0, 7) == 0);
            correctPc    = $urandom();
            correctType  = 1'($urandom_range(0, 1));
            correctIdx   = 4'($urandom_range(0, 9));
            rst          = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nbj_next_pc_unit.md
Name: nbj_next_pc_unit

Overview:
Parametrised, clocked successor of the next-PC/cut stage in instruction fetch. It accepts one aligned fetch packet per handshake and finds the first taken control-transfer lane. It emits the next fetch PC plus a keep-mask (cut position) over a registered valid/ready output. Back-end mispredict corrections take priority: the unit emits a redirect beat and pulses clear.

Parameters:
LANES, 10, instruction slots per fetch packet
ADDR_W, 32, PC/target width
TYPE_W, 3, per-lane type code width
INST_BYTES, 4, PC stride per instruction
RESET_PC, 0, o_nextPc value after reset
CNT_W, $clog2(LANES+1), width of instruction count

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
i_frontValid  in  1  packet present
o_frontReady  out  1  packet accepted when valid&ready
i_jumpMask  in  LANES  bit k = lane k is a control transfer
i_alignedInstructionNumber  in  CNT_W  valid lanes in packet
i_currentPc  in  ADDR_W  PC of lane 0
i_typeAndAddressTableBus  in  LANES*(TYPE_W+ADDR_W)  lane k = {type, target}, lane 0 in LSBs
i_correctValid  in  1  back-end redirect request
i_correctPc  in  ADDR_W  corrected PC
i_correctPcIndex  in  $clog2(LANES)  lane of mispredicted instruction
i_correctType  in  1  1 = should have been taken, 0 = should have fallen through
o_outValid  out  1  output beat valid
i_outReady  in  1  consumer accepts beat
o_nextPc  out  ADDR_W  next fetch PC
o_cutPosition  out  LANES  keep-mask, bit k = keep lane k
o_clear  out  1  redirect/flush marker, high with redirect beat

Behaviour:
- Reset (rst=0 at edge): state IDLE; o_outValid=0, o_nextPc=RESET_PC, o_cutPosition=0, o_clear=0.
- States: IDLE (no beat held), HOLD (normal beat held), REDIR (redirect beat held).
- o_frontReady = !i_correctValid && (IDLE || (HOLD && i_outReady)). Combinational; no front accept during REDIR.
- Taken lane: lane k with k < clamp(count, LANES), i_jumpMask[k]=1, and type in {1 direct, 2 cond-predicted-taken, 4 indirect/return}. Types 0 and 3 fall through. The lowest such k wins.
- Normal beat, registered 1 cycle after accept:
  - Taken lane found: nextPc = target[k], cut = bits 0..k set.
  - None found: nextPc = currentPc + INST_BYTES*count (mod 2^ADDR_W), cut = bits 0..count-1 set.
- count=0: packet accepted, no beat, state unchanged.
- count>LANES: clamped to LANES.
- Beat holds stable until i_outReady. HOLD with ready and a new accept → back-to-back beat. HOLD with ready and no accept → IDLE.
- Redirect (i_correctValid=1 at edge), any state:
  - Next cycle: REDIR, o_outValid=1, o_clear=1.
  - nextPc = i_correctType ? i_correctPc : i_correctPc+INST_BYTES.
  - cut = bits 0..i_correctPcIndex set.
  - Any held normal beat is discarded.
- REDIR with ready and no new redirect → IDLE with o_clear=0. A new redirect in REDIR replaces the payload; the newest wins.
- Redirect and front valid in the same cycle: redirect wins and the packet is not accepted.
- o_clear is high only while REDIR beat is valid.
- Mid-operation reset overrides everything and drops any held beat.

Optional Feature:
NBJ_PERF_CNT_EN: defined adds outputs o_takenCount (32b) and o_redirectCount (32b).
- o_takenCount increments per normal beat delivered with a taken lane.
- o_redirectCount increments per redirect beat delivered.
- Both saturate at 2^32-1 and reset to 0.
- Undefined: ports and logic absent, behaviour otherwise identical.

Test Plan:
- count=4, mask=0, currentPc=0x1000, ready=1 → one cycle later nextPc=0x1010, cut=0x00F, clear=0.
- count=8, mask=0x024, lane2 type3, lane5 type1 target 0x8000 → nextPc=0x8000, cut=0x03F.
- Packet with i_outReady=0 for 3 cycles → beat stable, o_frontReady=0; release gives next packet back-to-back.
- Redirect correctPc=0x2000, type0, index 3, concurrent front valid → front not accepted; beat nextPc=0x2004, cut=0x00F, clear=1 for one handshake; then IDLE.
- Redirect while a normal beat is held and ready=0 → normal beat dropped; redirect beat with clear=1 appears.
- rst=0 while HOLD → next cycle o_outValid=0, o_nextPc=RESET_PC, cut=0; with NBJ_PERF_CNT_EN, counters read 0.
